// File: rtl/lcd_power_sequencer_if.sv
// Control and status bundle between the top level and the LCD panel power sequencer.
// The master drives the request, vsync and brightness; the slave is the sequencer itself.
interface lcd_power_sequencer_if #(
    parameter int unsigned PWM_BITS = 8
);
    logic                enable;
    logic                vsync;
    logic [PWM_BITS-1:0] brightness;
    logic                panel_pwr;
    logic                timing_resetn;
    logic                video_en;
    logic                bl_pwm;
    logic                ready;

    modport master (
        output enable,
        output vsync,
        output brightness,
        input  panel_pwr,
        input  timing_resetn,
        input  video_en,
        input  bl_pwm,
        input  ready
    );

    modport slave (
        input  enable,
        input  vsync,
        input  brightness,
        output panel_pwr,
        output timing_resetn,
        output video_en,
        output bl_pwm,
        output ready
    );
endinterface

// File: rtl/lcd_power_sequencer.sv
// DPI LCD panel power sequencer: supply, timing reset release, frame-counted blanking,
// video enable and backlight PWM on power-up, reversed on power-down.
module lcd_power_sequencer #(
    parameter int unsigned PWR_DELAY    = 24000,
    parameter int unsigned OFF_DELAY    = 24000,
    parameter int unsigned BLANK_FRAMES = 2,
    parameter int unsigned BL_FRAMES    = 4,
    parameter int unsigned PWM_BITS     = 8
) (
    input logic                  clk,
    input logic                  resetn,
    lcd_power_sequencer_if.slave bus
);

    localparam int unsigned MaxDelay = (PWR_DELAY > OFF_DELAY) ? PWR_DELAY : OFF_DELAY;
    localparam int unsigned CntW     = $clog2(MaxDelay) + 1;

    localparam logic [CntW-1:0] PwrLast   = CntW'(PWR_DELAY - 1);
    localparam logic [CntW-1:0] OffLast   = CntW'(OFF_DELAY - 1);
    localparam logic [7:0]      BlankLast = 8'(BLANK_FRAMES - 1);
    localparam logic [7:0]      BlLast    = 8'(BL_FRAMES - 1);

    typedef enum logic [2:0] {
        StOff,
        StPwrUp,
        StBlank,
        StBlWait,
        StOn,
        StBlOff,
        StVidOff,
        StPwrDown
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [7:0]          fcnt_q, fcnt_d;
    logic                vsync_q;
    logic                vs_edge;

    logic                bl_on;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] brightness_q;
    logic                bl_pwm_q;

    // A vsync already high on entry to a counting state is not an edge, since
    // vsync_q tracks the input in every state.
    assign vs_edge = bus.vsync & ~vsync_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StOff;
            cnt_q   <= '0;
            fcnt_q  <= '0;
            vsync_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fcnt_q  <= fcnt_d;
            vsync_q <= bus.vsync;
        end
    end

    // Loss of enable takes priority over a counter reaching its terminal value.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            StOff: begin
                if (bus.enable) begin
                    state_d = StPwrUp;
                    cnt_d   = '0;
                end
            end
            StPwrUp: begin
                if (!bus.enable) begin
                    state_d = StPwrDown;
                    cnt_d   = '0;
                end else if (cnt_q == PwrLast) begin
                    state_d = StBlank;
                    fcnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StBlank: begin
                if (!bus.enable) begin
                    state_d = StPwrDown;
                    cnt_d   = '0;
                end else if (vs_edge) begin
                    if (fcnt_q == BlankLast) begin
                        state_d = StBlWait;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
            end
            StBlWait: begin
                if (!bus.enable) begin
                    state_d = StVidOff;
                end else if (vs_edge) begin
                    if (fcnt_q == BlLast) begin
                        state_d = StOn;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
            end
            StOn: begin
                if (!bus.enable) begin
                    state_d = StBlOff;
                end
            end
            StBlOff: begin
                if (vs_edge) begin
                    state_d = StVidOff;
                end
            end
            StVidOff: begin
                if (vs_edge) begin
                    state_d = StPwrDown;
                    cnt_d   = '0;
                end
            end
            StPwrDown: begin
                if (cnt_q == OffLast) begin
                    state_d = StOff;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StOff;
            end
        endcase
    end

    always_comb begin
        bus.panel_pwr     = 1'b0;
        bus.timing_resetn = 1'b0;
        bus.video_en      = 1'b0;
        bus.ready         = 1'b0;
        bl_on             = 1'b0;
        case (state_q)
            StPwrUp, StPwrDown: begin
                bus.panel_pwr = 1'b1;
            end
            StBlank, StVidOff: begin
                bus.panel_pwr     = 1'b1;
                bus.timing_resetn = 1'b1;
            end
            StBlWait, StBlOff: begin
                bus.panel_pwr     = 1'b1;
                bus.timing_resetn = 1'b1;
                bus.video_en      = 1'b1;
            end
            StOn: begin
                bus.panel_pwr     = 1'b1;
                bus.timing_resetn = 1'b1;
                bus.video_en      = 1'b1;
                bus.ready         = 1'b1;
                bl_on             = 1'b1;
            end
            default: begin
                bus.panel_pwr = 1'b0;
            end
        endcase
    end

    // Duty is latched at the period boundary so a brightness change never
    // produces a truncated or stretched pulse.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pwm_cnt_q    <= '0;
            brightness_q <= '0;
            bl_pwm_q     <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            if (&pwm_cnt_q) begin
                brightness_q <= bus.brightness;
            end
            bl_pwm_q <= bl_on & (pwm_cnt_q < brightness_q);
        end
    end

    assign bus.bl_pwm = bl_pwm_q;

endmodule

// File: tb/tb_lcd_power_sequencer.sv
// Scoreboard bench for lcd_power_sequencer: expected status-vector changes are queued with
// their cycle numbers; a negedge monitor pops and compares each observed change.
module tb_lcd_power_sequencer;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   failures = 0;
    logic mon_on = 1'b0;
    logic [3:0] prev_vec = 4'b0000;

    typedef struct {
        int         cyc;
        logic [3:0] vec;
    } exp_t;

    exp_t exp_q[$];

    lcd_power_sequencer_if #(.PWM_BITS(4)) bus ();

    lcd_power_sequencer #(
        .PWR_DELAY   (10),
        .OFF_DELAY   (5),
        .BLANK_FRAMES(2),
        .BL_FRAMES   (1),
        .PWM_BITS    (4)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // vsync is sampled high on edges 100n..100n+3, so each rising edge lands on edge 100n.
    initial begin
        bus.vsync = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.vsync = ((cyc + 1) % 100) < 4;
        end
    end

    always @(posedge clk) begin
        if (cyc > 3000) begin
            $display("FAIL watchdog: cycle %0d exceeded limit 3000", cyc);
            $fatal(1);
        end
    end

    // vec = {panel_pwr, timing_resetn, video_en, ready}
    always @(negedge clk) begin
        logic [3:0] cur;
        exp_t       e;
        cur = {bus.panel_pwr, bus.timing_resetn, bus.video_en, bus.ready};
        if (mon_on && (cur !== prev_vec)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_change: cycle %0d vec %b, expected no change", cyc, cur);
            end else begin
                e = exp_q.pop_front();
                if ((e.cyc != cyc) || (e.vec !== cur)) begin
                    failures++;
                    $display("FAIL out_change: cycle %0d vec %b, expected cycle %0d vec %b",
                             cyc, cur, e.cyc, e.vec);
                end
            end
            prev_vec = cur;
        end
    end

    task automatic push(input int c, input logic [3:0] v);
        exp_t e;
        e.cyc = c;
        e.vec = v;
        exp_q.push_back(e);
    endtask

    // Returns #1 after posedge number c.
    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Counts bl_pwm highs over edges first..first+15; optionally changes brightness mid-window.
    task automatic pwm_window(input int first, input int exp, input string name,
                              input int chg_at, input logic [3:0] chg_val);
        int hi;
        hi = 0;
        for (int n = first; n < first + 16; n++) begin
            goto(n);
            if (bus.bl_pwm === 1'b1) hi++;
            if (n == chg_at) bus.brightness = chg_val;
        end
        check(name, hi, exp);
    endtask

    initial begin
        int hi;
        bus.enable     = 1'b0;
        bus.brightness = 4'd5;
        resetn         = 1'b0;

        goto(3);
        check("reset_vec", int'({bus.panel_pwr, bus.timing_resetn, bus.video_en, bus.ready}), 0);
        check("reset_bl_pwm", int'(bus.bl_pwm), 0);
        prev_vec = 4'b0000;
        mon_on   = 1'b1;
        resetn   = 1'b1;

        // Power-up
        push(10, 4'b1000);
        push(20, 4'b1100);
        push(200, 4'b1110);
        push(300, 4'b1111);
        goto(9);
        bus.enable = 1'b1;

        // PWM: periods start on edges = 4 mod 16; duty latched on edges = 3 mod 16
        pwm_window(308, 5, "pwm_b5", 315, 4'd12);
        pwm_window(324, 12, "pwm_b12", -1, 4'd0);
        pwm_window(340, 12, "pwm_hold12", 340, 4'd0);
        pwm_window(356, 0, "pwm_b0_a", -1, 4'd0);
        pwm_window(372, 0, "pwm_b0_b", 387, 4'd5);

        // Power-down from ON
        push(410, 4'b1110);
        push(500, 4'b1100);
        push(600, 4'b1000);
        push(605, 4'b0000);
        goto(409);
        bus.enable = 1'b0;
        hi = 0;
        for (int n = 411; n <= 430; n++) begin
            goto(n);
            if (bus.bl_pwm !== 1'b0) hi++;
        end
        check("bl_pwm_off_after_drop", hi, 0);

        // Abort in PWR_UP at cnt=4
        push(620, 4'b1000);
        push(630, 4'b0000);
        goto(619);
        bus.enable = 1'b1;
        goto(624);
        bus.enable = 1'b0;

        // Abort in BLANK
        push(640, 4'b1000);
        push(650, 4'b1100);
        push(720, 4'b1000);
        push(725, 4'b0000);
        goto(639);
        bus.enable = 1'b1;
        goto(719);
        bus.enable = 1'b0;

        // Reset while ON, restart with enable held
        push(740, 4'b1000);
        push(750, 4'b1100);
        push(900, 4'b1110);
        push(1000, 4'b1111);
        push(1010, 4'b0000);
        push(1011, 4'b1000);
        push(1021, 4'b1100);
        push(1200, 4'b1110);
        push(1300, 4'b1111);
        goto(739);
        bus.enable = 1'b1;
        goto(1009);
        resetn = 1'b0;
        goto(1010);
        check("bl_pwm_after_reset", int'(bus.bl_pwm), 0);
        resetn = 1'b1;

        // Enable re-asserted during PWR_DOWN
        push(1310, 4'b1110);
        push(1400, 4'b1100);
        push(1500, 4'b1000);
        push(1505, 4'b0000);
        push(1506, 4'b1000);
        push(1513, 4'b0000);
        goto(1309);
        bus.enable = 1'b0;
        goto(1501);
        bus.enable = 1'b1;
        goto(1507);
        bus.enable = 1'b0;

        goto(1530);
        check("pending_expectations", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd_power_sequencer.md
# lcd_power_sequencer

Power-up/power-down sequencer and backlight PWM for the parallel-RGB (DPI) LCD panel on the GPIO header. Sits between the top level and the `vga_video` timing generator. It switches panel power, releases the timing generator's `resetn` after a power-settle delay, and blanks RGB for a number of frames. It then enables video and finally the backlight, and reverses the order on power-down.

## Interface
Parameters:
- `PWR_DELAY`, 24000: cycles from `panel_pwr` rising to `timing_resetn` rising (1 ms at 24 MHz); ≥1.
- `OFF_DELAY`, 24000: cycles from `timing_resetn` falling to `panel_pwr` falling; ≥1.
- `BLANK_FRAMES`, 2: vsync rising edges with timing running but video black before `video_en`; 1..255.
- `BL_FRAMES`, 4: vsync rising edges with video on before backlight enable; 1..255.
- `PWM_BITS`, 8: backlight PWM resolution.

Ports:
- `clk`, in, 1: pixel clock; the only clock.
- `resetn`, in, 1: synchronous, active-low reset.
- `enable`, in, 1: level request for the panel to be on.
- `vsync`, in, 1: from the timing generator, active high.
- `brightness`, in, `PWM_BITS`: backlight duty, in units of 1/2^`PWM_BITS`.
- `panel_pwr`, out, 1: panel supply enable.
- `timing_resetn`, out, 1: drives the timing generator's `resetn`.
- `video_en`, out, 1: high to pass RGB; low forces RGB to 0 at top level.
- `bl_pwm`, out, 1: backlight PWM.
- `ready`, out, 1: sequence complete, panel fully on.

## Operation
States and outputs (Moore; outputs decode the state register, except `bl_pwm`):
- OFF: all outputs 0.
- PWR_UP: `panel_pwr`.
- BLANK: `panel_pwr`, `timing_resetn`.
- BL_WAIT: `panel_pwr`, `timing_resetn`, `video_en`.
- ON: all of the above plus `bl_on` and `ready`.
- BL_OFF: same as BL_WAIT.
- VID_OFF: same as BLANK.
- PWR_DOWN: same as PWR_UP.

Edge detect:
- `vs_edge = vsync & ~vsync_d`, where `vsync_d` is registered.
- `vs_edge` is counted only in BLANK, BL_WAIT, BL_OFF and VID_OFF.

Transitions (an `enable`=0 abort has priority over count completion in the same cycle):
- OFF: `enable`=1 → PWR_UP, `cnt`=0.
- PWR_UP: `cnt`++ each cycle. At `cnt`==`PWR_DELAY`-1 → BLANK, `fcnt`=0. `enable`=0 → PWR_DOWN, `cnt`=0.
- BLANK: `fcnt`++ on `vs_edge`. On `vs_edge` with `fcnt`==`BLANK_FRAMES`-1 → BL_WAIT, `fcnt`=0. `enable`=0 → PWR_DOWN, `cnt`=0 (video already black).
- BL_WAIT: same counting against `BL_FRAMES`, then → ON. `enable`=0 → VID_OFF.
- ON: `enable`=0 → BL_OFF.
- BL_OFF: on `vs_edge` → VID_OFF.
- VID_OFF: on `vs_edge` → PWR_DOWN, `cnt`=0.
- PWR_DOWN: `cnt`++. At `cnt`==`OFF_DELAY`-1 → OFF. `enable` is ignored until OFF is reached; a held `enable`=1 restarts the sequence from OFF on the next cycle.

Counter widths:
- `cnt` is `$clog2(max(PWR_DELAY,OFF_DELAY))+1` bits.
- `fcnt` is 8 bits.
- No timeout: the timing generator runs whenever `timing_resetn` is high.

PWM:
- `pwm_cnt` is a `PWM_BITS`-bit free-running counter that wraps.
- `brightness_q` loads `brightness` only when `pwm_cnt` is all-ones, so duty changes only at period boundaries.
- `bl_pwm` is registered: `bl_pwm` <= `bl_on` & (`pwm_cnt` < `brightness_q`).
- `brightness`=0 gives constant low; all-ones gives (2^N-1)/2^N duty.

Reset (`resetn`=0 at an edge, any state, including mid-sequence):
- State → OFF; `cnt`, `fcnt`, `pwm_cnt`, `brightness_q`, `vsync_d`, `bl_pwm` → 0.
- All outputs are 0 in the following cycle. No orderly power-down is attempted.

## Timing
- `enable` sampled high at edge k → PWR_UP from k+1; `panel_pwr` high from k+1.
- PWR_UP lasts exactly `PWR_DELAY` cycles; `timing_resetn` rises at k+1+`PWR_DELAY`.
- BLANK ends on the edge sampling the `BLANK_FRAMES`-th `vs_edge`; `video_en` rises the cycle after.
- `bl_on` rises the cycle after the `BL_FRAMES`-th `vs_edge`. `bl_pwm` lags `bl_on` by 1 cycle.
- `enable` drop in ON: `bl_on` falls 1 cycle after sampling, `bl_pwm` falls 2 cycles after.
  - `video_en` falls after the next `vs_edge`.
  - `timing_resetn` falls after the following `vs_edge`.
  - `panel_pwr` falls `OFF_DELAY` cycles later.
- A `vsync` already high when counting starts is not an edge.

## Test plan
Test parameters: `PWR_DELAY`=10, `OFF_DELAY`=5, `BLANK_FRAMES`=2, `BL_FRAMES`=1, `PWM_BITS`=4; vsync period 100 cycles.
- Power-up: `enable`=1 at cycle 0 → `panel_pwr` at 1, `timing_resetn` at 11, `video_en` after the 2nd vsync edge, `ready` and backlight after the 3rd.
- Power-down from ON: `enable`=0 → `bl_pwm` stays 0 from +2 cycles, `video_en` low after the next edge, `timing_resetn` low after the edge after that, `panel_pwr` low 5 cycles later, state OFF.
- Aborts:
  - `enable`=0 at PWR_UP `cnt`=4 → PWR_DOWN; `timing_resetn` never rises; `panel_pwr` low 5 cycles later.
  - `enable`=0 during BLANK → `timing_resetn` low next cycle; `video_en` never rises.
- PWM with `brightness`=5:
  - 5 high / 11 low per 16-cycle period.
  - Change to 12 mid-period → new duty starts only at the next period.
  - `brightness`=0 → `bl_pwm` constant 0.
- `resetn`=0 in ON → all outputs 0 the next cycle. Releasing with `enable`=1 restarts the full sequence.
- `enable` re-asserted during PWR_DOWN → completes to OFF, then PWR_UP the next cycle.
